// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit: shift-add MUL/UMULL, restoring UDIV/SDIV, one operation in flight.
// Optional macro MDU_EARLY_TERM_EN: MUL finishes as soon as no multiplier bits remain.
module mdu_iter #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             div_zero
);

    typedef enum logic [2:0] {IDLE, SETUP, MUL, DIV, FIX, DONE} state_t;

    state_t              state;
    logic [CNTW-1:0]     cnt;
    logic [1:0]          op_r;
    logic [WIDTH-1:0]    a_r, b_r;
    logic [2*WIDTH-1:0]  acc, mc, acc_nxt;
    logic [WIDTH-1:0]    mb, mb_nxt;
    logic [WIDTH-1:0]    quo, rem, dvs, quo_nxt, rem_nxt;
    logic [WIDTH:0]      shf;
    logic                fits, mul_last, div_last;

    function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
        return n ? -v : v;
    endfunction

    // Magnitude of a two's-complement operand when the operation is signed.
    function automatic logic [WIDTH-1:0] mag(input logic sgn, input logic [WIDTH-1:0] v);
        return neg_if(sgn && v[WIDTH-1], v);
    endfunction

    always_comb begin
        acc_nxt = acc + (mb[0] ? mc : '0);
        mb_nxt  = mb >> 1;
        shf     = {rem, quo[WIDTH-1]};
        fits    = shf >= {1'b0, dvs};
        rem_nxt = fits ? WIDTH'(shf - {1'b0, dvs}) : shf[WIDTH-1:0];
        quo_nxt = {quo[WIDTH-2:0], fits};
        div_last = (cnt == CNTW'(WIDTH-1));
`ifdef MDU_EARLY_TERM_EN
        mul_last = div_last || (mb_nxt == '0);
`else
        mul_last = div_last;
`endif
    end

    // Control FSM and architectural outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            result_lo <= '0;
            result_hi <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= SETUP;
                        busy     <= 1'b1;
                        div_zero <= 1'b0;
                    end
                end
                SETUP: begin
                    cnt <= '0;
                    if (!op_r[1]) begin
                        state <= MUL;
                    end else if (b_r == '0) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        div_zero  <= 1'b1;
                        result_lo <= '1;
                        result_hi <= a_r;
                    end else begin
                        state <= DIV;
                    end
                end
                MUL: begin
                    cnt <= cnt + CNTW'(1);
                    if (mul_last) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result_lo <= acc_nxt[WIDTH-1:0];
                        result_hi <= op_r[0] ? acc_nxt[2*WIDTH-1:WIDTH] : '0;
                    end
                end
                DIV: begin
                    cnt <= cnt + CNTW'(1);
                    if (div_last) begin
                        if (op_r[0]) begin
                            state <= FIX;
                        end else begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            result_lo <= quo_nxt;
                            result_hi <= rem_nxt;
                        end
                    end
                end
                FIX: begin
                    state     <= DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    result_lo <= neg_if(a_r[WIDTH-1] ^ b_r[WIDTH-1], quo);
                    result_hi <= neg_if(a_r[WIDTH-1], rem);
                end
                DONE: state <= IDLE;
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Datapath registers (no reset; qualified by FSM state)
    always_ff @(posedge clk) begin
        case (state)
            IDLE: begin
                if (start) begin
                    op_r <= op;
                    a_r  <= src_a;
                    b_r  <= src_b;
                end
            end
            SETUP: begin
                acc <= '0;
                mc  <= {{WIDTH{1'b0}}, a_r};
                mb  <= b_r;
                rem <= '0;
                quo <= mag(op_r[0], a_r);
                dvs <= mag(op_r[0], b_r);
            end
            MUL: begin
                acc <= acc_nxt;
                mc  <= mc << 1;
                mb  <= mb_nxt;
            end
            DIV: begin
                rem <= rem_nxt;
                quo <= quo_nxt;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Scoreboard bench for mdu_iter: stimulus pushes model results, a negedge monitor pops on done.
module tb_mdu_iter;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a, src_b;
    logic             busy, done, div_zero;
    logic [WIDTH-1:0] result_lo, result_hi;

    mdu_iter #(.WIDTH(WIDTH), .CNTW(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .result_lo(result_lo), .result_hi(result_hi), .div_zero(div_zero)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [31:0] last_lo = '0, last_hi = '0;
    logic        done_q = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: plain arithmetic from the operation definitions.
    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        logic [63:0] p;
        int sa, sb;
        r.lo = '0; r.hi = '0; r.dz = 1'b0; r.acc = 0; r.lat = WIDTH + 1;
        if (!o[1]) begin
            p = 64'(a) * 64'(b);
            r.lo = p[31:0];
            r.hi = o[0] ? p[63:32] : 32'h0;
`ifdef MDU_EARLY_TERM_EN
            begin
                int hb;
                hb = 0;
                for (int i = 0; i < 32; i++) if (b[i]) hb = i;
                r.lat = hb + 2;
            end
`endif
        end else if (b == 32'h0) begin
            r.lo = 32'hFFFF_FFFF; r.hi = a; r.dz = 1'b1; r.lat = 1;
        end else if (!o[0]) begin
            r.lo = a / b; r.hi = a % b;
        end else begin
            r.lat = WIDTH + 2;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                r.lo = a; r.hi = 32'h0;
            end else begin
                sa = $signed(a); sb = $signed(b);
                r.lo = 32'(sa / sb); r.hi = 32'(sa % sb);
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (reset_n) begin
            if (done_q) chk("done_width", 64'(done), 64'(0));
            if (done) begin
                if (sbq.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_done: got done=1 lo=0x%0h, expected no done", result_lo);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("result_lo", 64'(result_lo), 64'(mon_e.lo));
                    chk("result_hi", 64'(result_hi), 64'(mon_e.hi));
                    chk("div_zero", 64'(div_zero), 64'(mon_e.dz));
                    chk("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
                    last_lo = mon_e.lo; last_hi = mon_e.hi;
                end
            end else begin
                chk("hold_lo", 64'(result_lo), 64'(last_lo));
                chk("hold_hi", 64'(result_hi), 64'(last_hi));
            end
        end else begin
            last_lo = '0; last_hi = '0;
        end
        done_q = done && reset_n;
    end

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((busy || done) && g < 200) begin @(negedge clk); g++; end
        if (busy || done) chk("idle_timeout", 64'(busy || done), 64'(0));
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        start = 1'b1; op = o; src_a = a; src_b = b;
        e = model(o, a, b);
        e.acc = cyc + 1;
        sbq.push_back(e);
    endtask

    task automatic drain(input bit spam);
        int g = 0;
        while (sbq.size() != 0 && g < 300) begin
            @(negedge clk);
            start = spam && busy && ($urandom_range(0, 2) == 0);
            src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
            g++;
        end
        start = 1'b0;
        if (sbq.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got %0d outstanding, expected 0", sbq.size());
            sbq.delete();
        end
    endtask

    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit spam);
        wait_idle();
        issue(o, a, b);
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom; src_b = $urandom; op = 2'($urandom_range(0, 3));
        drain(spam);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset_n = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_lo", 64'(result_lo), 64'(0));
        chk("rst_hi", 64'(result_hi), 64'(0));
        chk("rst_dz", 64'(div_zero), 64'(0));
        reset_n = 1'b1;

        // Reset in the middle of a MUL: no done, outputs cleared.
        wait_idle();
        start = 1'b1; op = 2'b00; src_a = 32'd7; src_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_busy_pre", 64'(busy), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'(0));
        chk("midrst_done", 64'(done), 64'(0));
        chk("midrst_lo", 64'(result_lo), 64'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        do_op(2'b00, 32'd3, 32'd5, 1'b0);

        do_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'd100, 32'd7, 1'b0);
        do_op(2'b11, 32'hFFFF_FF9C, 32'd7, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(2'b10, 32'd5, 32'd0, 1'b0);

        // start held high with a changing src_a; only the first request runs.
        wait_idle();
        chk("dz_held", 64'(div_zero), 64'(1));
        issue(2'b00, 32'h0001_2345, 32'h0000_0101);
        @(negedge clk);
        chk("dz_cleared", 64'(div_zero), 64'(0));
        g = 0;
        while (!done && g < 300) begin
            src_a = $urandom;
            @(negedge clk);
            g++;
        end
        start = 1'b0;
        if (!done) chk("held_done_seen", 64'(done), 64'(1));
        drain(1'b0);
        do_op(2'b01, 32'hDEAD_BEEF, 32'h0000_0010, 1'b0);

        do_op(2'b00, 32'h0000_1234, 32'd3, 1'b0);
        do_op(2'b00, 32'h1234_5678, 32'd0, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd0, 1'b0);
        do_op(2'b11, 32'd100, 32'hFFFF_FFF9, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] b;
            case ($urandom_range(0, 4))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            do_op(2'($urandom_range(0, 3)), $urandom, b, 1'b1);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
